// File: rtl/qr_pkg.sv
// ============================================================================
// Module  : qr_pkg
// Brief   : Shared constants and types for the Q/R datapath stages.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package qr_pkg;

    localparam int QR_WIDTH = 16;
    localparam int QR_FRAC  = 14;
    localparam int QR_ACC_W = 2 * QR_WIDTH + 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MAC  = 1'b1
    } r_dot_state_t;

    typedef logic signed [QR_WIDTH-1:0] qfix_t;

endpackage : qr_pkg

`default_nettype wire

// File: rtl/round_sat.sv
// ============================================================================
// Module  : round_sat
// Brief   : Round-half-up and saturate a wide accumulator down to Q1.FRAC.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module round_sat
    import qr_pkg::*;
#(
    parameter int ACC_W = QR_ACC_W,
    parameter int WIDTH = QR_WIDTH,
    parameter int FRAC  = QR_FRAC
) (
    input  logic signed [ACC_W-1:0] acc_in,
    output logic signed [WIDTH-1:0] res_out,
    output logic                    clip
);

    localparam logic signed [ACC_W-1:0] HALF    = ACC_W'(1) <<< (FRAC - 1);
    localparam logic signed [ACC_W-1:0] MAX_VAL = ACC_W'((1 << (WIDTH - 1)) - 1);
    localparam logic signed [ACC_W-1:0] MIN_VAL = -MAX_VAL - ACC_W'(1);

    logic signed [ACC_W-1:0] rounded;
    logic signed [ACC_W-1:0] shifted;

    // Accumulator headroom guarantees the rounding add cannot wrap.
    always_comb begin
        rounded = acc_in + HALF;
        shifted = rounded >>> FRAC;
        clip    = 1'b0;
        res_out = shifted[WIDTH-1:0];
        if (shifted > MAX_VAL) begin
            res_out = MAX_VAL[WIDTH-1:0];
            clip    = 1'b1;
        end else if (shifted < MIN_VAL) begin
            res_out = MIN_VAL[WIDTH-1:0];
            clip    = 1'b1;
        end
    end

endmodule : round_sat

`default_nettype wire

// File: rtl/qr_r_dot.sv
// ============================================================================
// Module  : qr_r_dot
// Brief   : R-entry dot product r = q.a over three cycles with one multiplier.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module qr_r_dot
    import qr_pkg::*;
#(
    parameter int WIDTH = QR_WIDTH,
    parameter int FRAC  = QR_FRAC
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] q1,
    input  logic signed [WIDTH-1:0] q2,
    input  logic signed [WIDTH-1:0] q3,
    input  logic signed [WIDTH-1:0] a1,
    input  logic signed [WIDTH-1:0] a2,
    input  logic signed [WIDTH-1:0] a3,
    output logic signed [WIDTH-1:0] r,
    output logic                    done,
    output logic                    busy,
    output logic                    sat
);

    localparam int ACC_W  = 2 * WIDTH + 2;
    localparam int PROD_W = 2 * WIDTH;

    r_dot_state_t            state_q, state_d;
    logic [1:0]              idx_q, idx_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [WIDTH-1:0] q1_q, q2_q, q3_q, q1_d, q2_d, q3_d;
    logic signed [WIDTH-1:0] a1_q, a2_q, a3_q, a1_d, a2_d, a3_d;
    logic signed [WIDTH-1:0] r_q, r_d;
    logic                    done_q, done_d;
    logic                    sat_q, sat_d;

    logic signed [WIDTH-1:0]  mul_q, mul_a;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [WIDTH-1:0]  rs_res;
    logic                     rs_clip;

    always_comb begin
        mul_q = '0;
        mul_a = '0;
        case (idx_q)
            2'd0:    begin mul_q = q1_q; mul_a = a1_q; end
            2'd1:    begin mul_q = q2_q; mul_a = a2_q; end
            2'd2:    begin mul_q = q3_q; mul_a = a3_q; end
            default: begin mul_q = '0;   mul_a = '0;   end
        endcase
        prod     = mul_q * mul_a;
        acc_next = acc_q + $signed({{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod});
    end

    round_sat #(
        .ACC_W (ACC_W),
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_round_sat (
        .acc_in  (acc_next),
        .res_out (rs_res),
        .clip    (rs_clip)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        q1_d    = q1_q;
        q2_d    = q2_q;
        q3_d    = q3_q;
        a1_d    = a1_q;
        a2_d    = a2_q;
        a3_d    = a3_q;
        r_d     = r_q;
        sat_d   = sat_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    q1_d    = q1;
                    q2_d    = q2;
                    q3_d    = q3;
                    a1_d    = a1;
                    a2_d    = a2;
                    a3_d    = a3;
                    acc_d   = '0;
                    idx_d   = 2'd0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = acc_next;
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd2) begin
                    r_d     = rs_res;
                    sat_d   = rs_clip;
                    done_d  = 1'b1;
                    idx_d   = 2'd0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            q1_q    <= '0;
            q2_q    <= '0;
            q3_q    <= '0;
            a1_q    <= '0;
            a2_q    <= '0;
            a3_q    <= '0;
            r_q     <= '0;
            done_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            q1_q    <= q1_d;
            q2_q    <= q2_d;
            q3_q    <= q3_d;
            a1_q    <= a1_d;
            a2_q    <= a2_d;
            a3_q    <= a3_d;
            r_q     <= r_d;
            done_q  <= done_d;
            sat_q   <= sat_d;
        end
    end

    assign r    = r_q;
    assign done = done_q;
    assign sat  = sat_q;
    assign busy = (state_q == MAC);

endmodule : qr_r_dot

`default_nettype wire

// File: doc/qr_r_dot.md
# qr_r_dot

Computes one upper-triangular entry r = q·a of the QR factorisation: the dot product of the 3-element column q, held by the Q-load stage, with a 3-element column a of the input matrix. It sits directly downstream of the Q-load stage. Its `start` is driven by that stage's one-cycle `stop` pulse, and its `q1..q3` are driven by that stage's latched `q*_l` outputs. It uses one signed multiplier, time-shared over three cycles, and produces a rounded, saturated 16-bit result with a one-cycle `done` pulse.

## Interface
- WIDTH, 16, data width of q, a and r (signed two's complement)
- FRAC, 14, fractional bits; all data is Q1.14, so 0x4000 = 1.0
- Clock and reset are fixed: one clock; reset is synchronous and active-low.
- clk  in  1  clock; all state changes on its rising edge
- reset  in  1  synchronous reset, active-low: `reset==0` at a rising edge resets the block
- start  in  1  request pulse, driven by the Q-load stage's `stop`
- q1, q2, q3  in  WIDTH  Q-column elements, driven by the Q-load stage's `q*_l`
- a1, a2, a3  in  WIDTH  A-column elements, valid in the `start` cycle
- r  out  WIDTH  result; holds until the next completion
- done  out  1  one-cycle pulse; `r` and `sat` are valid while it is high
- busy  out  1  high while a computation is in flight
- sat  out  1  high when the last result was clipped; updates with `r`

## Operation
- States: IDLE and MAC. Two-bit index `idx` runs 0..2. Accumulator `acc` is signed, 2*WIDTH+2 = 34 bits.
- IDLE with `start==1`:
  - register q1..q3 and a1..a3 into internal operand registers;
  - clear `acc` and set `idx=0`;
  - go to MAC.
- IDLE with `start==0`: hold all state. `done` returns to 0.
- MAC, every cycle:
  - `acc_next = acc + sext(q[idx]*a[idx])`; the full 32-bit signed product is accumulated with no truncation;
  - register `acc_next` into `acc` and increment `idx`.
- MAC with `idx==2`, additionally:
  - `r <= round_sat(acc_next)`, `sat <= clip flag`, `done <= 1`;
  - go to IDLE.
- round_sat:
  - add 2^(FRAC-1), then arithmetic shift right by FRAC (rounds half toward +inf);
  - clamp to [0x8000, 0x7FFF];
  - the clip flag is set when the value was clamped.
- `start` is ignored while in MAC (no queueing). Operands change only on an accepted `start`.
- `busy = (state==MAC)`, decoded combinationally from the state register.
- Reset values: state=IDLE, idx=0, acc=0, operand registers=0, r=0, done=0, sat=0, busy=0.
- Reset mid-operation (`reset==0` during MAC): abort. No `done` pulse is issued, and `r` is cleared to 0.
- Reset and `start` in the same cycle: reset wins; `start` is dropped.

## Timing
- `start` is sampled at edge T. `busy` is high in cycles T+1..T+3.
- MAC accumulates at edges T+1, T+2 and T+3.
- `done`, `r` and `sat` are registered at edge T+3, so `done` is high for exactly the cycle after edge T+3.
- Latency: 3 cycles from the `start` edge to `done`.
- Back-to-back: a `start` in the `done` cycle (state is IDLE) is accepted. Maximum rate is one result per 4 cycles.
- `r` and `sat` are stable from `done` until the next completion or reset.
- Compatible with the Q-load stage: its `stop` rises one cycle after its own `start`, with `q*_l` already valid in that cycle.

## Structure
- Shared package `qr_pkg` holds:
  - constants QR_WIDTH=16, QR_FRAC=14, QR_ACC_W=34;
  - enum `r_dot_state_t` {IDLE, MAC};
  - the fixed-point data typedef `qfix_t` (logic signed [15:0]).
- One sub-module, `round_sat`: combinational; QR_ACC_W input, WIDTH output plus a clip flag. It is shared with the other Q/R datapath stages.
- Top-level responsibilities: FSM, idx counter, operand registers, multiplier and accumulator.

## Test plan
- q=(0x4000,0,0), a=(0x2000,0x1000,0x7FFF), one `start` pulse:
  - `busy` high for 3 cycles;
  - `done` at start+3 with r=0x2000, sat=0.
- q=(0x2000,0x2000,0x2000), a=(0x4000,0x4000,0x4000): r=0x6000 (1.5), sat=0.
- Saturation:
  - q=a=(0x7FFF)x3 → r=0x7FFF, sat=1;
  - q=(0x4000)x3, a=(0x8000)x3 → r=0x8000, sat=1.
- Rounding:
  - q=(0x0001,0,0), a=(0x2000,0,0) → r=0x0001;
  - a=(0x1FFF,0,0) → r=0x0000;
  - q=(0xFFFF,0,0), a=(0x2000,0,0) → r=0x0000.
- Pulse `start` again at start+1 and start+2 with different a: ignored, result unchanged. Then pulse `start` in the `done` cycle: accepted, second `done` at +3.
- Drive `reset` low at start+2 (mid-MAC): busy=0, no `done` pulse, r=0. A subsequent normal run produces the correct r.
